// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder.
// Pops bytes from the keyboard receiver FIFO, folds E0/F0 prefixes into
// one event per key, tracks shift/ctrl/caps and translates to ASCII.
// A single-entry event register holds each event until the CPU reads it;
// while it is full the receiver is not popped, which provides backpressure.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_rdn,
  input  logic       rdn,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic       shift,
  output logic       ctrl,
  output logic       caps
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       shift_q, shift_d, ctrl_q, ctrl_d;
  logic       caps_q, caps_d, caps_held_q, caps_held_d;
  logic       kb_rdn_q, kb_rdn_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d, key_ascii_q, key_ascii_d;
  logic       key_ext_q, key_ext_d, key_break_q, key_break_d;

  // Letter scan code -> alphabet index 1..26 (0 if not a letter).
  function automatic logic [4:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: letter_idx = 5'd1;   8'h32: letter_idx = 5'd2;
      8'h21: letter_idx = 5'd3;   8'h23: letter_idx = 5'd4;
      8'h24: letter_idx = 5'd5;   8'h2B: letter_idx = 5'd6;
      8'h34: letter_idx = 5'd7;   8'h33: letter_idx = 5'd8;
      8'h43: letter_idx = 5'd9;   8'h3B: letter_idx = 5'd10;
      8'h42: letter_idx = 5'd11;  8'h4B: letter_idx = 5'd12;
      8'h3A: letter_idx = 5'd13;  8'h31: letter_idx = 5'd14;
      8'h44: letter_idx = 5'd15;  8'h4D: letter_idx = 5'd16;
      8'h15: letter_idx = 5'd17;  8'h2D: letter_idx = 5'd18;
      8'h1B: letter_idx = 5'd19;  8'h2C: letter_idx = 5'd20;
      8'h3C: letter_idx = 5'd21;  8'h2A: letter_idx = 5'd22;
      8'h1D: letter_idx = 5'd23;  8'h22: letter_idx = 5'd24;
      8'h35: letter_idx = 5'd25;  8'h1A: letter_idx = 5'd26;
      default: letter_idx = 5'd0;
    endcase
  endfunction

  // Non-letter keys -> {unshifted, shifted} glyph; control keys repeat the same code.
  function automatic logic [15:0] glyph_pair(input logic [7:0] c);
    case (c)
      8'h16: glyph_pair = {8'h31, 8'h21};  8'h1E: glyph_pair = {8'h32, 8'h40};
      8'h26: glyph_pair = {8'h33, 8'h23};  8'h25: glyph_pair = {8'h34, 8'h24};
      8'h2E: glyph_pair = {8'h35, 8'h25};  8'h36: glyph_pair = {8'h36, 8'h5E};
      8'h3D: glyph_pair = {8'h37, 8'h26};  8'h3E: glyph_pair = {8'h38, 8'h2A};
      8'h46: glyph_pair = {8'h39, 8'h28};  8'h45: glyph_pair = {8'h30, 8'h29};
      8'h4E: glyph_pair = {8'h2D, 8'h5F};  8'h55: glyph_pair = {8'h3D, 8'h2B};
      8'h54: glyph_pair = {8'h5B, 8'h7B};  8'h5B: glyph_pair = {8'h5D, 8'h7D};
      8'h5D: glyph_pair = {8'h5C, 8'h7C};  8'h4C: glyph_pair = {8'h3B, 8'h3A};
      8'h52: glyph_pair = {8'h27, 8'h22};  8'h0E: glyph_pair = {8'h60, 8'h7E};
      8'h41: glyph_pair = {8'h2C, 8'h3C};  8'h49: glyph_pair = {8'h2E, 8'h3E};
      8'h4A: glyph_pair = {8'h2F, 8'h3F};  8'h29: glyph_pair = {8'h20, 8'h20};
      8'h5A: glyph_pair = {8'h0D, 8'h0D};  8'h66: glyph_pair = {8'h08, 8'h08};
      8'h0D: glyph_pair = {8'h09, 8'h09};  8'h76: glyph_pair = {8'h1B, 8'h1B};
      default: glyph_pair = 16'h0000;
    endcase
  endfunction

  // Full translation using the modifier state in force before this key.
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic ext,
                                          input logic sh, input logic ct, input logic cp);
    logic [4:0]  idx;
    logic [15:0] g;
    idx = letter_idx(c);
    g   = glyph_pair(c);
    if (ext) begin
      if (c == 8'h4A)      to_ascii = 8'h2F;
      else if (c == 8'h5A) to_ascii = 8'h0D;
      else                 to_ascii = 8'h00;
    end else if (idx != 5'd0) begin
      if (ct)            to_ascii = {3'b000, idx};
      else if (sh ^ cp)  to_ascii = {3'b010, idx};
      else               to_ascii = {3'b011, idx};
    end else if (sh) begin
      to_ascii = g[7:0];
    end else begin
      to_ascii = g[15:8];
    end
  endfunction

  // Next-state logic: FSM sequencing, prefix tracking, modifiers and event register.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_ascii_d = key_ascii_q;

    // CPU read empties the event register; a DECODE load below never coincides.
    if (!rdn && key_valid_q) key_valid_d = 1'b0;
    else                     key_valid_d = key_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (kb_ready && !key_valid_q) state_d = ST_FETCH;
        else                          state_d = ST_IDLE;
      end
      ST_FETCH: begin
        code_d  = kb_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        case (code_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            // E0 12 / E0 59 are fake shifts emitted around nav keys: ignore.
            if (ext_q && (code_q == 8'h12 || code_q == 8'h59)) begin
              key_valid_d = key_valid_q;
            end else begin
              if (!ext_q && code_q == 8'h12) lshift_d = !brk_q;
              else                           lshift_d = lshift_q;
              if (!ext_q && code_q == 8'h59) rshift_d = !brk_q;
              else                           rshift_d = rshift_q;
              if (code_q == 8'h14) ctrl_d = !brk_q;
              else                 ctrl_d = ctrl_q;
              if (code_q == 8'h58) begin
                if (brk_q) begin
                  caps_held_d = 1'b0;
                end else if (!caps_held_q) begin
                  caps_d      = !caps_q;
                  caps_held_d = 1'b1;
                end else begin
                  caps_held_d = caps_held_q;
                end
              end else begin
                caps_held_d = caps_held_q;
              end
              key_valid_d = 1'b1;
              key_code_d  = code_q;
              key_ext_d   = ext_q;
              key_break_d = brk_q;
              key_ascii_d = to_ascii(code_q, ext_q, shift_q, ctrl_q, caps_q);
            end
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    shift_d  = lshift_d | rshift_d;
    kb_rdn_d = ~(state_d == ST_FETCH);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      kb_rdn_q    <= 1'b1;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_ascii_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      kb_rdn_q    <= kb_rdn_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_ascii_q <= key_ascii_d;
    end
  end

  assign kb_rdn    = kb_rdn_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign key_ascii = key_ascii_q;
  assign shift     = shift_q;
  assign ctrl      = ctrl_q;
  assign caps      = caps_q;

endmodule
